// File: rtl/cacheline_adaptor_if.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor_if
//
// Bundles the arbiter-side line port and the memory-side burst port of the
// cache-line adaptor. Signal suffixes are written from the adaptor's point of
// view (_i drives into the adaptor, _o comes out of it).
//
// Modports:
//   slave  - the adaptor itself
//   master - whatever drives the arbiter requests and models memory
//
// Signals:
//   read_i / write_i  line read / write request, held until resp_o
//   address_i         line address
//   line_i            256-bit write line
//   line_o            256-bit assembled read line
//   resp_o            one-cycle line completion pulse
//   address_o         burst address, low 5 bits forced to zero
//   read_o / write_o  burst read / write strobes
//   burst_o           current 64-bit write beat
//   burst_i           64-bit read beat, valid with resp_i
//   resp_i            memory accepted or delivered one beat
//   err_o             watchdog abort pulse (only with ADAPTOR_TIMEOUT_EN)
// -----------------------------------------------------------------------------
interface cacheline_adaptor_if;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;
`ifdef ADAPTOR_TIMEOUT_EN
  logic         err_o;
`endif

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
`ifdef ADAPTOR_TIMEOUT_EN
    output err_o,
`endif
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
`ifdef ADAPTOR_TIMEOUT_EN
    input  err_o,
`endif
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Turns each 256-bit cache-line transfer from the arbiter into four 64-bit
// beats on a burst memory port, lowest beat first. Read beats are collected in
// a line buffer and published to line_o only when the last beat arrives; write
// lines are latched on acceptance and serialized beat by beat. Completion is a
// single-cycle resp_o pulse from the DONE state.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - cacheline_adaptor_if.slave, arbiter and memory signals
//
// Parameters:
//   BEATS   - beats per line, fixed at 4 by the 256/64 width ratio
//   TIMEOUT - watchdog limit in cycles (only with ADAPTOR_TIMEOUT_EN)
//
// Optional feature: define ADAPTOR_TIMEOUT_EN to add a watchdog that aborts a
// burst after TIMEOUT consecutive cycles without resp_i, pulsing err_o along
// with resp_o. Without it the adaptor waits indefinitely for memory.
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int BEATS = 4
`ifdef ADAPTOR_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input logic               clk,
  input logic               rst,
  cacheline_adaptor_if.slave bus
);

  localparam int              CntW     = $clog2(BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  // Shared between transfers: holds the latched write line, or the beats of
  // a read collected so far. Only one transfer is ever in flight.
  logic [255:0]    buf_q, buf_d;
  // Published read line; only touched when a read completes normally, so it
  // survives writes, resets-free aborts and partial reads.
  logic [255:0]    line_q, line_d;

`ifdef ADAPTOR_TIMEOUT_EN
  localparam int              WdW     = $clog2(TIMEOUT);
  localparam logic [WdW-1:0]  WdLimit = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  // State and datapath registers; reset returns everything to zero at once,
  // discarding any partial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
`ifdef ADAPTOR_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
`ifdef ADAPTOR_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic. Writes win over reads in IDLE. The last read beat goes
  // straight into line_d together with the three buffered beats, so line_o
  // changes only on a completed read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    line_d  = line_q;
`ifdef ADAPTOR_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          addr_d  = {bus.address_i[31:5], 5'b0};
          buf_d   = bus.line_i;
          cnt_d   = '0;
          state_d = WR;
`ifdef ADAPTOR_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else if (bus.read_i) begin
          addr_d  = {bus.address_i[31:5], 5'b0};
          cnt_d   = '0;
          state_d = RD;
`ifdef ADAPTOR_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      RD, WR: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + CntW'(1);
          if (state_q == RD) begin
            buf_d[64*cnt_q +: 64] = bus.burst_i;
            if (cnt_q == LastBeat) begin
              line_d = {bus.burst_i, buf_q[191:0]};
            end
          end
          if (cnt_q == LastBeat) begin
            state_d = DONE;
          end
`ifdef ADAPTOR_TIMEOUT_EN
          wd_d = '0;
        end else if (wd_q == WdLimit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WdW'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode from state and registers only.
  assign bus.read_o    = (state_q == RD);
  assign bus.write_o   = (state_q == WR);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.line_o    = line_q;
  assign bus.burst_o   = (state_q == WR) ? buf_q[64*cnt_q +: 64] : 64'h0;
`ifdef ADAPTOR_TIMEOUT_EN
  assign bus.err_o     = err_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Directed bench for cacheline_adaptor. Plays the arbiter and a simple memory
// that answers beats after a configurable number of idle cycles. Cycle numbers
// count the request cycle as cycle 1, so a stall-free transfer completes with
// resp_o high in cycle 6.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cacheline_adaptor_if bus ();

  cacheline_adaptor #(
    .BEATS(4)
`ifdef ADAPTOR_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Last-resort guard in case a transfer never ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Arbiter + memory model for one line read; no checking here. Returns the
  // cycle in which resp_o was seen, the line at that moment, the burst
  // address seen while reading, and the first cycle read_o was seen.
  task automatic applyRead(input logic [31:0] addr, input logic [255:0] beats,
                           input int stall, output int respCycle,
                           output logic [255:0] lineSeen, output logic [31:0] addrSeen,
                           output int firstRead);
    int beatIdx;
    int waitCnt;
    beatIdx   = 0;
    waitCnt   = 0;
    respCycle = 0;
    firstRead = 0;
    lineSeen  = '0;
    addrSeen  = '0;
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (bus.resp_o) begin
        respCycle = c + 1;
        lineSeen  = bus.line_o;
        break;
      end
      if (bus.read_o) begin
        addrSeen = bus.address_o;
        if (firstRead == 0) firstRead = c + 1;
      end
      bus.resp_i = 1'b0;
      if (bus.read_o && beatIdx < 4) begin
        if (waitCnt < stall) begin
          waitCnt++;
        end else begin
          bus.resp_i  = 1'b1;
          bus.burst_i = beats[64*beatIdx +: 64];
          beatIdx++;
          waitCnt = 0;
        end
      end
    end
    bus.read_i    = 1'b0;
    bus.resp_i    = 1'b0;
    bus.address_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #3;
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_o: got %b expected 0", bus.read_o); end
    checks++; if (bus.write_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_o: got %b expected 0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_o: got %b expected 0", bus.resp_o); end
    checks++; if (bus.burst_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_burst_o: got %h expected 0", bus.burst_o); end
    checks++; if (bus.address_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_address_o: got %h expected 0", bus.address_o); end
    checks++; if (bus.line_o !== 256'h0) begin errors++; $display("[TB] FAIL reset_line_o: got %h expected 0", bus.line_o); end
`ifdef ADAPTOR_TIMEOUT_EN
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_o: got %b expected 0", bus.err_o); end
`endif
    #9;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_read_no_stall;
    logic [255:0] beats;
    logic [255:0] lineSeen;
    logic [31:0]  addrSeen;
    int           respCycle;
    int           firstRead;
    beats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    applyRead(32'h0000_1234, beats, 0, respCycle, lineSeen, addrSeen, firstRead);
    checks++; if (respCycle !== 6) begin errors++; $display("[TB] FAIL read_resp_cycle: got %0d expected 6", respCycle); end
    checks++; if (firstRead !== 2) begin errors++; $display("[TB] FAIL read_accept_cycle: got %0d expected 2", firstRead); end
    checks++; if (addrSeen !== 32'h0000_1220) begin errors++; $display("[TB] FAIL read_address_o: got %h expected 00001220", addrSeen); end
    checks++; if (lineSeen !== beats) begin errors++; $display("[TB] FAIL read_line_o: got %h expected %h", lineSeen, beats); end
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("[TB] FAIL read_done_read_o: got %b expected 0", bus.read_o); end
    tick;
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("[TB] FAIL read_resp_pulse: got %b expected 0", bus.resp_o); end
    checks++; if (bus.line_o !== beats) begin errors++; $display("[TB] FAIL read_line_held: got %h expected %h", bus.line_o, beats); end
  endtask

  task automatic test_write_stall;
    logic [255:0] prevLine;
    logic [63:0]  expBeat;
    int           beatIdx;
    int           waitCnt;
    int           respCycle;
    prevLine = bus.line_o;
    beatIdx  = 0;
    waitCnt  = 0;
    respCycle = 0;
    bus.address_i = 32'h0000_8047;
    bus.line_i    = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                     64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    bus.write_i   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (bus.resp_o) begin
        respCycle = c + 1;
        break;
      end
      bus.resp_i = 1'b0;
      if (bus.write_o && beatIdx < 4) begin
        expBeat = {32'hDEAD_BEEF, beatIdx[31:0]};
        checks++; if (bus.burst_o !== expBeat) begin errors++; $display("[TB] FAIL write_burst_o: cycle %0d got %h expected %h", c + 1, bus.burst_o, expBeat); end
        checks++; if (bus.address_o !== 32'h0000_8040) begin errors++; $display("[TB] FAIL write_address_o: got %h expected 00008040", bus.address_o); end
        if (waitCnt < 2) begin
          waitCnt++;
        end else begin
          bus.resp_i = 1'b1;
          beatIdx++;
          waitCnt = 0;
        end
      end
    end
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
    checks++; if (respCycle !== 14) begin errors++; $display("[TB] FAIL write_resp_cycle: got %0d expected 14", respCycle); end
    checks++; if (beatIdx !== 4) begin errors++; $display("[TB] FAIL write_beat_count: got %0d expected 4", beatIdx); end
    checks++; if (bus.write_o !== 1'b0) begin errors++; $display("[TB] FAIL write_done_write_o: got %b expected 0", bus.write_o); end
    checks++; if (bus.line_o !== prevLine) begin errors++; $display("[TB] FAIL write_line_o_held: got %h expected %h", bus.line_o, prevLine); end
    tick;
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("[TB] FAIL write_resp_pulse: got %b expected 0", bus.resp_o); end
  endtask

  task automatic test_simultaneous;
    int respCycle;
    int writeCycles;
    int readCycles;
    respCycle   = 0;
    writeCycles = 0;
    readCycles  = 0;
    bus.address_i = 32'h0000_0300;
    bus.line_i    = {4{64'h0123_4567_89AB_CDEF}};
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (bus.resp_o) begin
        respCycle = c + 1;
        break;
      end
      if (bus.read_o) readCycles++;
      bus.resp_i = 1'b0;
      if (bus.write_o) begin
        writeCycles++;
        bus.resp_i = 1'b1;
      end
    end
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
    checks++; if (readCycles !== 0) begin errors++; $display("[TB] FAIL simul_read_o_cycles: got %0d expected 0", readCycles); end
    checks++; if (writeCycles !== 4) begin errors++; $display("[TB] FAIL simul_write_o_cycles: got %0d expected 4", writeCycles); end
    checks++; if (respCycle !== 6) begin errors++; $display("[TB] FAIL simul_resp_cycle: got %0d expected 6", respCycle); end
    tick;
  endtask

  task automatic test_reset_mid_burst;
    logic [255:0] beats;
    logic [255:0] lineSeen;
    logic [31:0]  addrSeen;
    int           respCycle;
    int           firstRead;
    bus.address_i = 32'h0000_ABCD;
    bus.read_i    = 1'b1;
    tick;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hAAAA_0000_0000_0001;
    tick;
    bus.burst_i = 64'hAAAA_0000_0000_0002;
    tick;
    bus.resp_i = 1'b0;
    checks++; if (bus.address_o !== 32'h0000_ABC0) begin errors++; $display("[TB] FAIL midrst_address_before: got %h expected 0000abc0", bus.address_o); end
    checks++; if (bus.read_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_read_o_before: got %b expected 1", bus.read_o); end
    #2;
    rst = 1'b0;
    bus.read_i = 1'b0;
    bus.address_i = '0;
    #1;
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_read_o: got %b expected 0", bus.read_o); end
    checks++; if (bus.address_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_address_o: got %h expected 0", bus.address_o); end
    checks++; if (bus.line_o !== 256'h0) begin errors++; $display("[TB] FAIL midrst_line_o: got %h expected 0", bus.line_o); end
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_resp_o: got %b expected 0", bus.resp_o); end
    #3;
    rst = 1'b1;
    tick;
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_resp: got %b expected 0", bus.resp_o); end
    beats = {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
             64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1};
    applyRead(32'h0000_0040, beats, 1, respCycle, lineSeen, addrSeen, firstRead);
    checks++; if (lineSeen !== beats) begin errors++; $display("[TB] FAIL midrst_reread_line: got %h expected %h", lineSeen, beats); end
    checks++; if (respCycle !== 10) begin errors++; $display("[TB] FAIL midrst_reread_cycle: got %0d expected 10", respCycle); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [255:0] beatsA;
    logic [255:0] beatsB;
    logic [255:0] lineSeen;
    logic [31:0]  addrSeen;
    int           respCycle;
    int           firstRead;
    beatsA = {64'h0000_0000_0000_0A03, 64'h0000_0000_0000_0A02,
              64'h0000_0000_0000_0A01, 64'h0000_0000_0000_0A00};
    beatsB = {64'hFFFF_0000_0000_0B03, 64'hFFFF_0000_0000_0B02,
              64'hFFFF_0000_0000_0B01, 64'hFFFF_0000_0000_0B00};
    applyRead(32'h0000_0100, beatsA, 0, respCycle, lineSeen, addrSeen, firstRead);
    checks++; if (lineSeen !== beatsA) begin errors++; $display("[TB] FAIL b2b_first_line: got %h expected %h", lineSeen, beatsA); end
    tick;
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_resp_double: got %b expected 0", bus.resp_o); end
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got read_o %b expected 0", bus.read_o); end
    applyRead(32'h0000_0200, beatsB, 0, respCycle, lineSeen, addrSeen, firstRead);
    checks++; if (firstRead !== 2) begin errors++; $display("[TB] FAIL b2b_second_accept: got %0d expected 2", firstRead); end
    checks++; if (addrSeen !== 32'h0000_0200) begin errors++; $display("[TB] FAIL b2b_second_addr: got %h expected 00000200", addrSeen); end
    checks++; if (lineSeen !== beatsB) begin errors++; $display("[TB] FAIL b2b_second_line: got %h expected %h", lineSeen, beatsB); end
    checks++; if (respCycle !== 6) begin errors++; $display("[TB] FAIL b2b_second_cycle: got %0d expected 6", respCycle); end
    tick;
  endtask

`ifdef ADAPTOR_TIMEOUT_EN
  task automatic test_timeout;
    logic [255:0] prevLine;
    int           respCycle;
    logic         errSeen;
    prevLine  = bus.line_o;
    respCycle = 0;
    errSeen   = 1'b0;
    bus.address_i = 32'h0000_0500;
    bus.read_i    = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (bus.resp_o) begin
        respCycle = c + 1;
        errSeen   = bus.err_o;
        break;
      end
    end
    bus.read_i = 1'b0;
    checks++; if (respCycle !== 10) begin errors++; $display("[TB] FAIL timeout_resp_cycle: got %0d expected 10", respCycle); end
    checks++; if (errSeen !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_o: got %b expected 1", errSeen); end
    checks++; if (bus.line_o !== prevLine) begin errors++; $display("[TB] FAIL timeout_line_held: got %h expected %h", bus.line_o, prevLine); end
    tick;
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_pulse: got %b expected 0", bus.err_o); end
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle: got read_o %b expected 0", bus.read_o); end
  endtask
`endif

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;

    test_reset();
    test_read_no_stall();
    test_write_stall();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef ADAPTOR_TIMEOUT_EN
    test_timeout();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Sequences the 256-bit cache-line transfers issued by the cache arbiter onto a 64-bit burst memory port. Each line transfer becomes four beats, lowest 64 bits first. Read beats are assembled into a line register, write lines are serialized from a latched copy, and completion is returned to the arbiter as a single-cycle `resp_o` pulse. The block sits between the cache arbiter and physical memory, replacing a direct 256-bit memory connection.

## Interface
- `BEATS`, 4: beats per line. Fixed by the 256/64 width ratio; not to be overridden.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only under `ADAPTOR_TIMEOUT_EN`.
- `clk` in 1: clock. All state changes on its rising edge.
- `rst` in 1: **asynchronous, active-low reset**. Low clears all state immediately.
- `read_i` in 1: line read request from the arbiter. Held until `resp_o`.
- `write_i` in 1: line write request from the arbiter. Held until `resp_o`.
- `address_i` in 32: line address.
- `line_i` in 256: write line.
- `line_o` out 256: assembled read line. Valid while `resp_o` is high, and held until the next read completes.
- `resp_o` out 1: one-cycle completion pulse.
- `address_o` out 32: burst address. Equals the latched address with `[4:0]` forced to 0.
- `read_o` out 1: burst read strobe.
- `write_o` out 1: burst write strobe.
- `burst_o` out 64: current write beat.
- `burst_i` in 64: read beat. Valid when `resp_i` is high.
- `resp_i` in 1: memory accepted or delivered one beat.
- `err_o` out 1: timeout abort pulse. The port exists only under `ADAPTOR_TIMEOUT_EN`.

## Operation
- FSM states: `IDLE`, `RD`, `WR`, `DONE`. A 2-bit beat counter `cnt`.
- Reset: state `IDLE`, `cnt`=0, line register and address latch all 0. `read_o`, `write_o`, `resp_o`, `err_o` all 0; `burst_o`=0; `address_o`=0; `line_o`=0.
- `IDLE`:
  - `write_i`=1: latch `address_i` and `line_i`, clear `cnt`, go to `WR`.
  - Otherwise `read_i`=1: latch `address_i`, clear `cnt`, go to `RD`.
  - Write takes priority when `read_i` and `write_i` are both high.
- `RD`:
  - `read_o`=1.
  - Each cycle with `resp_i`=1: store `burst_i` into line bits `[64*cnt+63 : 64*cnt]`, then increment `cnt`.
  - On the beat where `cnt`=3, go to `DONE`.
  - `resp_i` may stall (stay 0) between beats; `read_o` stays high throughout.
- `WR`:
  - `write_o`=1.
  - `burst_o` = latched line bits `[64*cnt+63 : 64*cnt]`.
  - Each `resp_i`=1 advances `cnt`; the beat where `cnt`=3 goes to `DONE`.
- `DONE`:
  - `resp_o`=1 for exactly one cycle; `read_o` and `write_o` are 0.
  - Unconditional transition to `IDLE`.
  - The arbiter drops its request in response, so no transfer is re-issued.
- `resp_i` outside `RD`/`WR` is ignored.
- `address_i`, `line_i` and request changes after the latch cycle are ignored until `IDLE`.
- `rst` low mid-burst: abort immediately to the reset values. The partial line is discarded and no `resp_o` is produced.

## Timing
- Request acceptance: request high in `IDLE` at edge N; `read_o` or `write_o` is high from N+1.
- Completion: last beat at edge M; `resp_o` high in cycle M+1 only.
- Back-to-back: `IDLE` is occupied for at least one cycle between transfers.
- Minimum transfer: 1 (accept) + 4 (beats) + 1 (`DONE`) = 6 cycles from request to `resp_o`.
- All outputs are registered or decoded from state and latches only; there is no combinational path from any input to any output.

## Configuration
- `ADAPTOR_TIMEOUT_EN` defined:
  - Adds a watchdog counter cleared on entry to `RD`/`WR` and on every `resp_i`.
  - Reaching `TIMEOUT` consecutive cycles with no `resp_i` in `RD`/`WR` forces `DONE` with `err_o`=1 and `resp_o`=1 in the same cycle.
  - `line_o` keeps its previous value on that abort.
- `ADAPTOR_TIMEOUT_EN` undefined:
  - No counter and no `err_o` port.
  - The block waits indefinitely for `resp_i`.

## Test plan
- Read, no stalls:
  - Stimulus: `read_i`=1, `address_i`=0x0000_1234. Memory returns `resp_i` on 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: `address_o`=0x0000_1220; `line_o`=0x44..44_33..33_22..22_11..11; `resp_o` high exactly 6 cycles after the request.
- Write with stalls:
  - Stimulus: `write_i`=1, `line_i`={4{0xDEAD_BEEF_0000_000k}}, with 2 idle cycles before each `resp_i`.
  - Required: `burst_o` steps through the beats in order, each held through its stall; `resp_o` at cycle 14.
- Simultaneous requests:
  - Stimulus: `read_i`=`write_i`=1 in `IDLE`.
  - Required: `write_o` asserted and `read_o` stays 0 for the whole transfer.
- Reset mid-burst:
  - Stimulus: `rst` driven low after 2 read beats.
  - Required: all outputs 0 in the same cycle; a subsequent read of 4 beats returns a correct line with no stale beats.
- Back-to-back reads:
  - Stimulus: second read issued the cycle after `resp_o`.
  - Required: exactly one `IDLE` cycle between the two transfers; `resp_o` never high for two consecutive cycles.
- Timeout (`ADAPTOR_TIMEOUT_EN`, `TIMEOUT`=8):
  - Stimulus: read with no `resp_i`.
  - Required: `err_o`=`resp_o`=1 at cycle 10, then `IDLE`.
